// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared types for the Simple CPU control sequencer:
//     opcode_e  - instruction opcodes (IR upper bits)
//     state_e   - sequencer states
//     alu_op_e  - ALU function select driven toward the datapath
//     ctrl_t    - bundled strobe vector produced by the output decoder
//   Optional feature macro: CPU_CTRL_SINGLE_STEP_EN (adds the S_WAIT state).
package cpu_ctrl_pkg;

  localparam int OPW_DEFAULT = 4;

  typedef enum logic [3:0] {
    OPC_NOP   = 4'h0,
    OPC_LOAD  = 4'h1,
    OPC_STORE = 4'h2,
    OPC_ADD   = 4'h3,
    OPC_SUB   = 4'h4,
    OPC_JMP   = 4'h5,
    OPC_JZ    = 4'h6,
    OPC_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_FETCH3 = 4'd2,
    S_DECODE = 4'd3,
    S_OP1    = 4'd4,
    S_OP2    = 4'd5,
    S_OP3    = 4'd6,
    S_ST1    = 4'd7,
    S_ST2    = 4'd8,
    S_ST3    = 4'd9,
    S_EX_JMP = 4'd10,
    S_EX_JZ  = 4'd11,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    S_HALT   = 4'd12,
    S_WAIT   = 4'd13
`else
    S_HALT   = 4'd12
`endif
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    pc_inc;
    logic    pc_load;
    logic    mar_load;
    logic    mar_sel_pc;
    logic    mdr_load;
    logic    mdr_sel_acc;
    logic    ir_load;
    logic    acc_load;
    alu_op_e alu_op;
    logic    mem_rd;
    logic    mem_wr;
    logic    halted;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_outdec.sv
// cpu_ctrl_outdec
//   Purely combinational decoder from sequencer state to datapath strobes.
//   Ports:
//     state   in   state_e   current sequencer state
//     alu_sel in   alu_op_e  ALU function latched at DECODE (used in S_OP3 only)
//     ctrl    out  ctrl_t    strobe vector
//   The EX_JZ pc_load depends on z_flag and is added by the top.
module cpu_ctrl_outdec
  import cpu_ctrl_pkg::*;
(
  input  state_e  state,
  input  alu_op_e alu_sel,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1: begin
        ctrl.mar_load   = 1'b1;
        ctrl.mar_sel_pc = 1'b1;
      end
      S_FETCH2: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.mdr_load = 1'b1;
        ctrl.pc_inc   = 1'b1;
      end
      S_FETCH3: ctrl.ir_load = 1'b1;
      S_OP1:    ctrl.mar_load = 1'b1;
      S_OP2: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.mdr_load = 1'b1;
      end
      S_OP3: begin
        ctrl.acc_load = 1'b1;
        ctrl.alu_op   = alu_sel;
      end
      S_ST1:    ctrl.mar_load = 1'b1;
      S_ST2: begin
        ctrl.mdr_load    = 1'b1;
        ctrl.mdr_sel_acc = 1'b1;
      end
      S_ST3:    ctrl.mem_wr  = 1'b1;
      S_EX_JMP: ctrl.pc_load = 1'b1;
      S_HALT:   ctrl.halted  = 1'b1;
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Moore sequencer for the Simple CPU datapath (fetch / decode / execute).
//   Ports:
//     clk, rst (async, active-low), opcode[OPW] (sampled in DECODE),
//     z_flag (sampled in EX_JZ), step (only with CPU_CTRL_SINGLE_STEP_EN),
//     strobes pc_inc, pc_load, mar_load, mar_sel_pc, mdr_load, mdr_sel_acc,
//     ir_load, acc_load, alu_op[2], mem_rd, mem_wr, status halted, illegal_op,
//     dbg_state[4] exposes the state register.
//   Optional feature macro: CPU_CTRL_SINGLE_STEP_EN - adds the step input and
//   a WAIT state entered on reset and after every instruction.
//   Handshake: none; strobes are level signals consumed by the datapath on
//   the next rising clk edge. All strobes are forced low while rst is low.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_load,
  output logic           mar_sel_pc,
  output logic           mdr_load,
  output logic           mdr_sel_acc,
  output logic           ir_load,
  output logic           acc_load,
  output logic [1:0]     alu_op,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           halted,
  output logic           illegal_op,
  output logic [3:0]     dbg_state
);

`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam state_e RESTART = S_WAIT;
`else
  localparam state_e RESTART = S_FETCH1;
`endif

  state_e  state_q, state_d;
  alu_op_e alu_q, alu_d;     // ALU function carried from DECODE to OP3
  logic    illegal_d;
  ctrl_t   dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESTART;
      alu_q   <= ALU_PASS;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_d     = alu_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPW'(OPC_NOP):   state_d = RESTART;
          OPW'(OPC_LOAD):  begin state_d = S_OP1; alu_d = ALU_PASS; end
          OPW'(OPC_ADD):   begin state_d = S_OP1; alu_d = ALU_ADD;  end
          OPW'(OPC_SUB):   begin state_d = S_OP1; alu_d = ALU_SUB;  end
          OPW'(OPC_STORE): state_d = S_ST1;
          OPW'(OPC_JMP):   state_d = S_EX_JMP;
          OPW'(OPC_JZ):    state_d = S_EX_JZ;
          OPW'(OPC_HALT):  state_d = S_HALT;
          default: begin
            state_d   = RESTART;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_OP1:    state_d = S_OP2;
      S_OP2:    state_d = S_OP3;
      S_OP3:    state_d = RESTART;
      S_ST1:    state_d = S_ST2;
      S_ST2:    state_d = S_ST3;
      S_ST3:    state_d = RESTART;
      S_EX_JMP: state_d = RESTART;
      S_EX_JZ:  state_d = RESTART;
      S_HALT:   state_d = S_HALT;   // only rst leaves HALT
`ifdef CPU_CTRL_SINGLE_STEP_EN
      S_WAIT:   if (step) state_d = S_FETCH1;
`endif
      default:  state_d = RESTART;
    endcase
  end

  cpu_ctrl_outdec u_outdec (
    .state   (state_q),
    .alu_sel (alu_q),
    .ctrl    (dec)
  );

  // Gate every output with rst so an asserted reset drops strobes at once.
  always_comb begin
    pc_inc      = rst & dec.pc_inc;
    pc_load     = rst & (dec.pc_load | ((state_q == S_EX_JZ) & z_flag));
    mar_load    = rst & dec.mar_load;
    mar_sel_pc  = rst & dec.mar_sel_pc;
    mdr_load    = rst & dec.mdr_load;
    mdr_sel_acc = rst & dec.mdr_sel_acc;
    ir_load     = rst & dec.ir_load;
    acc_load    = rst & dec.acc_load;
    alu_op      = rst ? dec.alu_op : 2'b00;
    mem_rd      = rst & dec.mem_rd;
    mem_wr      = rst & dec.mem_wr;
    halted      = rst & dec.halted;
    illegal_op  = rst & illegal_d;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit
//   Directed-vector bench for cpu_control_unit. Outputs are packed into a
//   14-bit observation word:
//   [13]pc_inc [12]pc_load [11]mar_load [10]mar_sel_pc [9]mdr_load
//   [8]mdr_sel_acc [7]ir_load [6]acc_load [5:4]alu_op [3]mem_rd [2]mem_wr
//   [1]halted [0]illegal_op
module tb_cpu_control_unit;

  localparam logic [13:0] E_IDLE = 14'h0000;
  localparam logic [13:0] E_F1   = 14'h0C00;
  localparam logic [13:0] E_F2   = 14'h2208;
  localparam logic [13:0] E_F3   = 14'h0080;
  localparam logic [13:0] E_DEC  = 14'h0000;
  localparam logic [13:0] E_ILL  = 14'h0001;
  localparam logic [13:0] E_OP1  = 14'h0800;
  localparam logic [13:0] E_OP2  = 14'h0208;
  localparam logic [13:0] E_LD3  = 14'h0040;
  localparam logic [13:0] E_ADD3 = 14'h0050;
  localparam logic [13:0] E_SUB3 = 14'h0060;
  localparam logic [13:0] E_ST1  = 14'h0800;
  localparam logic [13:0] E_ST2  = 14'h0300;
  localparam logic [13:0] E_ST3  = 14'h0004;
  localparam logic [13:0] E_PCLD = 14'h1000;
  localparam logic [13:0] E_HALT = 14'h0002;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] opcode;
  logic       z_flag;
  logic       step;
  logic       pc_inc, pc_load, mar_load, mar_sel_pc, mdr_load, mdr_sel_acc;
  logic       ir_load, acc_load, mem_rd, mem_wr, halted, illegal_op;
  logic [1:0] alu_op;
  logic [3:0] dbg_state;
  logic [13:0] obs;

  assign obs = {pc_inc, pc_load, mar_load, mar_sel_pc, mdr_load, mdr_sel_acc,
                ir_load, acc_load, alu_op, mem_rd, mem_wr, halted, illegal_op};

  cpu_control_unit #(.OPW(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step        (step),
`endif
    .opcode      (opcode),
    .z_flag      (z_flag),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .mar_load    (mar_load),
    .mar_sel_pc  (mar_sel_pc),
    .mdr_load    (mdr_load),
    .mdr_sel_acc (mdr_sel_acc),
    .ir_load     (ir_load),
    .acc_load    (acc_load),
    .alu_op      (alu_op),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge where the DUT sits at an instruction start. Drives
  // opcode/z_flag, then checks one queued word per cycle at each negedge.
  task automatic run_trace(input string name, input logic [3:0] opc, input logic z);
    int i;
    opcode = opc;
    z_flag = z;
    i = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s[%0d]", name, i), obs, exp_q.pop_front());
      i++;
      @(negedge clk);
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back(E_F1);
    exp_q.push_back(E_F2);
    exp_q.push_back(E_F3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold0", obs, E_IDLE);
    @(negedge clk);
    check("rst_hold1", obs, E_IDLE);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    opcode = 4'h0;
    z_flag = 1'b0;
    step   = 1'b0;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    do_reset();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wait_idle[%0d]", k), obs, E_IDLE);
      @(negedge clk);
    end
    opcode = 4'h0;
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(negedge clk);
    push_fetch(); exp_q.push_back(E_DEC);
    exp_q.push_back(E_IDLE); exp_q.push_back(E_IDLE); exp_q.push_back(E_IDLE);
    run_trace("step_nop", 4'h0, 1'b0);
`else
    do_reset();
    check("rst_release", obs, E_F1);

    push_fetch(); exp_q.push_back(E_DEC);
    run_trace("nop", 4'h0, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC);
    exp_q.push_back(E_OP1); exp_q.push_back(E_OP2); exp_q.push_back(E_LD3);
    run_trace("load", 4'h1, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC);
    exp_q.push_back(E_ST1); exp_q.push_back(E_ST2); exp_q.push_back(E_ST3);
    run_trace("store", 4'h2, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC);
    exp_q.push_back(E_OP1); exp_q.push_back(E_OP2); exp_q.push_back(E_ADD3);
    run_trace("add", 4'h3, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC);
    exp_q.push_back(E_OP1); exp_q.push_back(E_OP2); exp_q.push_back(E_SUB3);
    run_trace("sub", 4'h4, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC); exp_q.push_back(E_PCLD);
    run_trace("jmp", 4'h5, 1'b0);

    push_fetch(); exp_q.push_back(E_DEC); exp_q.push_back(E_PCLD);
    run_trace("jz_taken", 4'h6, 1'b1);

    push_fetch(); exp_q.push_back(E_DEC); exp_q.push_back(E_IDLE);
    run_trace("jz_not", 4'h6, 1'b0);

    push_fetch(); exp_q.push_back(E_ILL);
    run_trace("illegal7", 4'h7, 1'b0);

    push_fetch(); exp_q.push_back(E_ILL);
    run_trace("illegalA", 4'hA, 1'b0);

    check("after_illegal", obs, E_F1);

    // reset asserted while in OP2 of a LOAD
    push_fetch(); exp_q.push_back(E_DEC); exp_q.push_back(E_OP1);
    run_trace("ld_abort", 4'h1, 1'b0);
    check("abort_op2", obs, E_OP2);
    #2 rst = 1'b0;
    #1 check("abort_async", obs, E_IDLE);
    @(negedge clk);
    check("abort_hold", obs, E_IDLE);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    push_fetch(); exp_q.push_back(E_DEC);
    run_trace("restart_nop", 4'h0, 1'b0);

    // halt holds with no strobes, regardless of later opcode/z_flag
    push_fetch(); exp_q.push_back(E_DEC);
    for (int k = 0; k < 22; k++) exp_q.push_back(E_HALT);
    run_trace("halt", 4'hF, 1'b0);
    opcode = 4'h1;
    z_flag = 1'b1;
    check("halt_stays", obs, E_HALT);

    do_reset();
    check("rst_after_halt", obs, E_F1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
